fwvexrisc_wb_bridge: RTL and testbench

- Parametrised bridge between the VexRiscv simple iBus/dBus interfaces and a single Wishbone initiator port.
- Arbitrates instruction and data commands and issues one classic Wishbone cycle at a time.
- Returns the read data and error status to the requesting channel.
- Successor to the fixed 32-bit bridge, adding:
  - configurable data width;
  - selectable arbitration policy;
  - Wishbone error propagation;
  - configurable turnaround.

---
 rtl/fwvexrisc_wb_bridge.sv | 223 ++++++++++++++++++++++
 tb/tb_fwvexrisc_wb_bridge.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwvexrisc_wb_bridge.sv
// fwvexrisc_wb_bridge
// Bridges the VexRiscv simple iBus/dBus command/response channels onto one
// classic Wishbone initiator port. One Wishbone cycle is outstanding at a
// time. Arbitration is fixed data-priority (ARB_MODE=0) or round-robin
// (ARB_MODE=1). DATA_WIDTH may be 32 or 64; the core side is always 32-bit.
// Optional watchdog: define FWVEXRISC_WB_BRIDGE_TIMEOUT_EN to end a cycle with
// an error response after TIMEOUT_CYCLES cycles without i_ack/i_err.
module fwvexrisc_wb_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ARB_MODE       = 0,
  parameter int TURNAROUND     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    iBus_cmd_valid,
  output logic                    iBus_cmd_ready,
  input  logic [31:0]             iBus_cmd_payload_pc,
  output logic                    iBus_rsp_valid,
  output logic                    iBus_rsp_payload_error,
  output logic [31:0]             iBus_rsp_payload_inst,
  input  logic                    dBus_cmd_valid,
  output logic                    dBus_cmd_ready,
  input  logic                    dBus_cmd_payload_wr,
  input  logic [31:0]             dBus_cmd_payload_address,
  input  logic [31:0]             dBus_cmd_payload_data,
  input  logic [1:0]              dBus_cmd_payload_size,
  output logic                    dBus_rsp_ready,
  output logic                    dBus_rsp_error,
  output logic [31:0]             dBus_rsp_data,
  output logic [ADDR_WIDTH-1:0]   i_adr,
  output logic [DATA_WIDTH-1:0]   i_dat_w,
  input  logic [DATA_WIDTH-1:0]   i_dat_r,
  output logic                    i_cyc,
  output logic                    i_stb,
  output logic                    i_we,
  output logic [DATA_WIDTH/8-1:0] i_sel,
  input  logic                    i_ack,
  input  logic                    i_err
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  // A 64-bit bus is addressed in 8-byte units; lane selects pick the bytes.
  localparam logic [31:0] ADDR_ALIGN = (DATA_WIDTH == 64) ? 32'hFFFF_FFF8 : 32'hFFFF_FFFF;

  typedef enum logic [1:0] {IDLE, DATA, INST, TURN} state_t;

  state_t                state, state_next;
  logic [1:0]            turn_cnt, turn_cnt_next;
  logic                  rr_data;       // 1: data wins the next simultaneous request
  logic                  prio_d;
  logic                  grant_d, grant_i;
  logic                  in_cycle, timeout_hit, timeout_only;
  logic                  wb_done, wb_error;
  logic [3:0]            mask4;
  logic [SEL_WIDTH-1:0]  sel_d;
  logic [DATA_WIDTH-1:0] dat_w_d;
  logic [31:0]           rd_word, rsp_word;

  // Truncate or zero-extend a 32-bit core address to the Wishbone width.
  function automatic logic [ADDR_WIDTH-1:0] fit_addr(input logic [31:0] a);
    logic [ADDR_WIDTH-1:0] r;
    r = '0;
    for (int b = 0; b < ADDR_WIDTH && b < 32; b++) r[b] = a[b];
    return r;
  endfunction

  // State register, turnaround counter and round-robin pointer.
  always_ff @(posedge clock) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state    <= IDLE;
      turn_cnt <= '0;
      rr_data  <= 1'b1;
    end else begin
      state    <= state_next;
      turn_cnt <= turn_cnt_next;
      if (grant_d)      rr_data <= 1'b0;
      else if (grant_i) rr_data <= 1'b1;
    end
  end

  assign in_cycle     = (state == DATA) || (state == INST);
  assign wb_done      = in_cycle && (i_ack || i_err || timeout_hit);
  assign timeout_only = timeout_hit && !i_ack && !i_err;
  assign wb_error     = i_err || timeout_only;
  assign rsp_word     = timeout_only ? 32'd0 : rd_word;
  assign prio_d       = (ARB_MODE == 0) ? 1'b1 : rr_data;

  // Grant, next state and turnaround count.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    state_next    = state;
    turn_cnt_next = turn_cnt;
    grant_d       = 1'b0;
    grant_i       = 1'b0;
    case (state)
      IDLE: begin
        grant_d = dBus_cmd_valid && (!iBus_cmd_valid || prio_d);
        grant_i = iBus_cmd_valid && (!dBus_cmd_valid || !prio_d);
        if (grant_d)      state_next = DATA;
        else if (grant_i) state_next = INST;
      end
      DATA, INST: begin
        if (wb_done) begin
          if (TURNAROUND == 0) begin
            state_next = IDLE;
          end else begin
            state_next    = TURN;
            turn_cnt_next = 2'(TURNAROUND - 1);
          end
        end
      end
      TURN: begin
        if (turn_cnt == 2'd0) state_next = IDLE;
        else                  turn_cnt_next = turn_cnt - 2'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign dBus_cmd_ready = grant_d;
  assign iBus_cmd_ready = grant_i;

  // Core-side 4-lane byte mask from transfer size and low address bits.
  always_comb begin
    mask4 = 4'b1111;
    case (dBus_cmd_payload_size)
      2'd0:    mask4 = 4'b0001 << dBus_cmd_payload_address[1:0];
      2'd1:    mask4 = dBus_cmd_payload_address[1] ? 4'b1100 : 4'b0011;
      default: mask4 = 4'b1111;
    endcase
  end

  generate
    if (DATA_WIDTH == 64) begin : g_w64
      logic adr_hi_q;
      // Remember which 32-bit half of the bus the current cycle targets.
      always_ff @(posedge clock) begin
        if (reset)        adr_hi_q <= 1'b0;
        else if (grant_d) adr_hi_q <= dBus_cmd_payload_address[2];
        else if (grant_i) adr_hi_q <= iBus_cmd_payload_pc[2];
      end
      assign sel_d   = dBus_cmd_payload_address[2] ? {mask4, 4'b0000} : {4'b0000, mask4};
      assign dat_w_d = {dBus_cmd_payload_data, dBus_cmd_payload_data};
      assign rd_word = adr_hi_q ? i_dat_r[63:32] : i_dat_r[31:0];
    end else begin : g_w32
      assign sel_d   = mask4;
      assign dat_w_d = dBus_cmd_payload_data;
      assign rd_word = i_dat_r;
    end
  endgenerate

  // Wishbone request registers and one-cycle response pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      i_adr                  <= '0;
      i_dat_w                <= '0;
      i_sel                  <= '0;
      i_we                   <= 1'b0;
      i_cyc                  <= 1'b0;
      i_stb                  <= 1'b0;
      iBus_rsp_valid         <= 1'b0;
      iBus_rsp_payload_error <= 1'b0;
      iBus_rsp_payload_inst  <= '0;
      dBus_rsp_ready         <= 1'b0;
      dBus_rsp_error         <= 1'b0;
      dBus_rsp_data          <= '0;
    end else begin
      iBus_rsp_valid         <= 1'b0;
      iBus_rsp_payload_error <= 1'b0;
      dBus_rsp_ready         <= 1'b0;
      dBus_rsp_error         <= 1'b0;
      if (grant_d) begin
        i_adr   <= fit_addr(dBus_cmd_payload_address & ADDR_ALIGN);
        i_we    <= dBus_cmd_payload_wr;
        i_dat_w <= dat_w_d;
        i_sel   <= sel_d;
        i_cyc   <= 1'b1;
        i_stb   <= 1'b1;
      end else if (grant_i) begin
        i_adr   <= fit_addr(iBus_cmd_payload_pc & ADDR_ALIGN);
        i_we    <= 1'b0;
        i_dat_w <= '0;
        i_sel   <= '1;
        i_cyc   <= 1'b1;
        i_stb   <= 1'b1;
      end
      if (wb_done) begin
        i_cyc <= 1'b0;
        i_stb <= 1'b0;
        if (state == DATA) begin
          dBus_rsp_ready <= 1'b1;
          dBus_rsp_error <= wb_error;
          dBus_rsp_data  <= rsp_word;
        end else begin
          iBus_rsp_valid         <= 1'b1;
          iBus_rsp_payload_error <= wb_error;
          iBus_rsp_payload_inst  <= rsp_word;
        end
      end
    end
  end

`ifdef FWVEXRISC_WB_BRIDGE_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt;

  // Count cycles the current Wishbone cycle has been outstanding.
  always_ff @(posedge clock) begin
    if (reset || grant_d || grant_i) to_cnt <= '0;
    else if (in_cycle)               to_cnt <= to_cnt + 1'b1;
  end

  assign timeout_hit = in_cycle && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  // Without the watchdog a cycle waits for i_ack/i_err indefinitely.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_fwvexrisc_wb_bridge.sv
// Directed bench for fwvexrisc_wb_bridge.
// Instance A: 32-bit bus, round-robin, TURNAROUND=2, TIMEOUT_CYCLES=8.
// Instance B: 64-bit bus, fixed data priority, TURNAROUND=0.
module tb_fwvexrisc_wb_bridge;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Instance A signals
  logic        a_iv, a_ir, a_irv, a_ire;
  logic [31:0] a_pc, a_inst;
  logic        a_dv, a_dr, a_dwr, a_drr, a_dre;
  logic [31:0] a_dadr, a_ddat, a_drd;
  logic [1:0]  a_dsz;
  logic [31:0] a_adr, a_dat_w, a_dat_r;
  logic        a_cyc, a_stb, a_we, a_ack, a_err;
  logic [3:0]  a_sel;

  // Instance B signals
  logic        b_iv, b_ir, b_irv, b_ire;
  logic [31:0] b_pc, b_inst;
  logic        b_dv, b_dr, b_dwr, b_drr, b_dre;
  logic [31:0] b_dadr, b_ddat, b_drd;
  logic [1:0]  b_dsz;
  logic [31:0] b_adr;
  logic [63:0] b_dat_w, b_dat_r;
  logic        b_cyc, b_stb, b_we, b_ack, b_err;
  logic [7:0]  b_sel;

  fwvexrisc_wb_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(1), .TURNAROUND(2), .TIMEOUT_CYCLES(8)
  ) u_a (
    .clock(clock), .reset(reset),
    .iBus_cmd_valid(a_iv), .iBus_cmd_ready(a_ir), .iBus_cmd_payload_pc(a_pc),
    .iBus_rsp_valid(a_irv), .iBus_rsp_payload_error(a_ire), .iBus_rsp_payload_inst(a_inst),
    .dBus_cmd_valid(a_dv), .dBus_cmd_ready(a_dr), .dBus_cmd_payload_wr(a_dwr),
    .dBus_cmd_payload_address(a_dadr), .dBus_cmd_payload_data(a_ddat),
    .dBus_cmd_payload_size(a_dsz), .dBus_rsp_ready(a_drr), .dBus_rsp_error(a_dre),
    .dBus_rsp_data(a_drd),
    .i_adr(a_adr), .i_dat_w(a_dat_w), .i_dat_r(a_dat_r), .i_cyc(a_cyc), .i_stb(a_stb),
    .i_we(a_we), .i_sel(a_sel), .i_ack(a_ack), .i_err(a_err)
  );

  fwvexrisc_wb_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .ARB_MODE(0), .TURNAROUND(0), .TIMEOUT_CYCLES(255)
  ) u_b (
    .clock(clock), .reset(reset),
    .iBus_cmd_valid(b_iv), .iBus_cmd_ready(b_ir), .iBus_cmd_payload_pc(b_pc),
    .iBus_rsp_valid(b_irv), .iBus_rsp_payload_error(b_ire), .iBus_rsp_payload_inst(b_inst),
    .dBus_cmd_valid(b_dv), .dBus_cmd_ready(b_dr), .dBus_cmd_payload_wr(b_dwr),
    .dBus_cmd_payload_address(b_dadr), .dBus_cmd_payload_data(b_ddat),
    .dBus_cmd_payload_size(b_dsz), .dBus_rsp_ready(b_drr), .dBus_rsp_error(b_dre),
    .dBus_rsp_data(b_drd),
    .i_adr(b_adr), .i_dat_w(b_dat_w), .i_dat_r(b_dat_r), .i_cyc(b_cyc), .i_stb(b_stb),
    .i_we(b_we), .i_sel(b_sel), .i_ack(b_ack), .i_err(b_err)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One dBus transaction on instance B, acked one cycle after the cycle starts.
  task automatic b_txn(input string tag, input logic wr, input logic [31:0] adr,
                       input logic [31:0] wdat, input logic [1:0] sz,
                       input logic [31:0] exp_adr, input logic [7:0] exp_sel,
                       input logic [63:0] rdat, input logic [31:0] exp_rd);
    b_dv = 1'b1; b_dwr = wr; b_dadr = adr; b_ddat = wdat; b_dsz = sz;
    #1;
    check({tag, "_dready"}, b_dr, 1'b1);
    check({tag, "_iready"}, b_ir, 1'b0);
    step();
    check({tag, "_adr"}, b_adr, exp_adr);
    check({tag, "_sel"}, b_sel, exp_sel);
    check({tag, "_we"}, b_we, wr);
    check({tag, "_dat_w"}, b_dat_w, {wdat, wdat});
    check({tag, "_cyc"}, {b_cyc, b_stb}, 2'b11);
    b_dat_r = rdat; b_ack = 1'b1;
    step();
    b_ack = 1'b0;
    check({tag, "_rsp"}, {b_drr, b_dre, b_irv}, 3'b100);
    check({tag, "_rdata"}, b_drd, exp_rd);
    check({tag, "_cyc_end"}, b_cyc, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit exp_d;
    a_iv = 0; a_pc = 0; a_dv = 0; a_dwr = 0; a_dadr = 0; a_ddat = 0; a_dsz = 0;
    a_dat_r = 0; a_ack = 0; a_err = 0;
    b_iv = 0; b_pc = 0; b_dv = 0; b_dwr = 0; b_dadr = 0; b_ddat = 0; b_dsz = 0;
    b_dat_r = 0; b_ack = 0; b_err = 0;

    // Reset values
    reset = 1'b1;
    step(); step();
    check("rst_ctrl", {a_cyc, a_stb, a_we, a_sel}, 7'd0);
    check("rst_adr_dat", {a_adr, a_dat_w}, 64'd0);
    check("rst_rsp", {a_drr, a_dre, a_irv, a_ire, a_dr, a_ir}, 6'd0);
    check("rst_rdata", {a_drd, a_inst}, 64'd0);
    check("rst_b", {b_cyc, b_stb, b_we, b_sel, b_drr, b_irv}, 13'd0);
    reset = 1'b0;
    step();

    // A: word store at 0x100, ack in the third cycle of the Wishbone cycle
    a_dv = 1; a_dwr = 1; a_dadr = 32'h100; a_ddat = 32'hDEAD_BEEF; a_dsz = 2'd2;
    #1;
    check("st_dready", a_dr, 1'b1);
    check("st_iready", a_ir, 1'b0);
    step();
    check("st_adr", a_adr, 32'h100);
    check("st_sel", a_sel, 4'hF);
    check("st_we", a_we, 1'b1);
    check("st_dat_w", a_dat_w, 32'hDEAD_BEEF);
    check("st_cyc_stb", {a_cyc, a_stb}, 2'b11);
    check("st_busy_dready", a_dr, 1'b0);
    a_dv = 0;
    step();
    check("st_wait", {a_cyc, a_drr}, 2'b10);
    step();
    a_ack = 1;
    step();
    a_ack = 0;
    check("st_rsp", {a_drr, a_dre, a_irv}, 3'b100);
    check("st_end_cyc", {a_cyc, a_stb}, 2'b00);
    // byte load queued during turnaround
    a_dv = 1; a_dwr = 0; a_dadr = 32'h103; a_ddat = 0; a_dsz = 2'd0;
    #1;
    check("turn1_dready", a_dr, 1'b0);
    step();
    check("st_rsp_pulse", a_drr, 1'b0);
    check("turn2_dready", a_dr, 1'b0);
    step();
    check("idle_dready", a_dr, 1'b1);
    step();
    a_dv = 0;
    check("ld_sel", a_sel, 4'b1000);
    check("ld_we", a_we, 1'b0);
    check("ld_adr", a_adr, 32'h103);
    a_dat_r = 32'h1122_3344; a_ack = 1;
    step();
    a_ack = 0;
    check("ld_rsp", {a_drr, a_dre, a_irv}, 3'b100);
    check("ld_data", a_drd, 32'h1122_3344);
    // stray ack with no cycle open
    step();
    a_ack = 1; a_dat_r = 32'h9999_9999;
    step();
    a_ack = 0;
    check("stray_rsp", {a_drr, a_irv}, 2'b00);
    check("stray_hold", a_drd, 32'h1122_3344);
    check("stray_cyc", a_cyc, 1'b0);

    // A: fetch at 0x200 terminated by i_err
    a_iv = 1; a_pc = 32'h200;
    #1;
    check("f_ready", {a_ir, a_dr}, 2'b10);
    step();
    a_iv = 0;
    check("f_adr", a_adr, 32'h200);
    check("f_sel_we", {a_sel, a_we}, 5'b11110);
    a_err = 1;
    step();
    a_err = 0;
    check("f_rsp", {a_irv, a_ire, a_drr}, 3'b110);
    step();
    check("f_err_clear", {a_irv, a_ire}, 2'b00);
    step();

    // A: round-robin with both channels requesting
    a_dv = 1; a_dwr = 0; a_dadr = 32'h40; a_dsz = 2'd2; a_iv = 1; a_pc = 32'h80;
    for (int k = 0; k < 4; k++) begin
      exp_d = (k % 2 == 0);
      #1;
      check("rr_ready", {a_dr, a_ir}, {exp_d, !exp_d});
      step();
      check("rr_adr", a_adr, exp_d ? 32'h40 : 32'h80);
      a_dat_r = 32'h1000 + k; a_ack = 1;
      step();
      a_ack = 0;
      check("rr_rsp", {a_drr, a_irv}, {exp_d, !exp_d});
      check("rr_rdata", exp_d ? a_drd : a_inst, 32'h1000 + k);
      step(); step();
    end
    a_dv = 0; a_iv = 0;

    // A: reset asserted during a data cycle, ack arrives late
    a_dv = 1; a_dwr = 1; a_dadr = 32'h300; a_ddat = 32'h1234_5678; a_dsz = 2'd2;
    step();
    a_dv = 0;
    check("mr_cyc", a_cyc, 1'b1);
    reset = 1; a_ack = 1;
    step();
    reset = 0;
    check("mr_cyc_off", {a_cyc, a_stb}, 2'b00);
    check("mr_rsp", {a_drr, a_irv}, 2'b00);
    step();
    a_ack = 0;
    check("mr_late_ack", {a_drr, a_irv, a_cyc}, 3'b000);
    a_dv = 1; a_dwr = 0; a_dadr = 32'h304;
    #1;
    check("mr_dready", a_dr, 1'b1);
    step();
    a_dv = 0;
    check("mr_adr", a_adr, 32'h304);
    a_dat_r = 32'hCAFE_F00D; a_ack = 1;
    step();
    a_ack = 0;
    check("mr_rsp2", {a_drr, a_dre}, 2'b10);
    check("mr_data", a_drd, 32'hCAFE_F00D);
    step(); step();

    // B: 64-bit bus, fixed priority, iBus held valid throughout
    b_iv = 1; b_pc = 32'h20C;
    b_txn("b0", 1'b1, 32'h106, 32'hBEEF_BEEF, 2'd1, 32'h100, 8'hC0, 64'h0, 32'h0);
    b_txn("b1", 1'b0, 32'h104, 32'h0, 2'd2, 32'h100, 8'hF0,
          64'h1111_2222_3333_4444, 32'h1111_2222);
    b_txn("b2", 1'b0, 32'h100, 32'h0, 2'd2, 32'h100, 8'h0F,
          64'h1111_2222_3333_4444, 32'h3333_4444);
    b_txn("b3", 1'b1, 32'h105, 32'h5A5A_5A5A, 2'd0, 32'h100, 8'h20, 64'h0, 32'h0);
    b_dv = 0;
    #1;
    check("bf_ready", {b_ir, b_dr}, 2'b10);
    step();
    b_iv = 0;
    check("bf_adr", b_adr, 32'h208);
    check("bf_sel_we", {b_sel, b_we}, 9'b1111_1111_0);
    b_dat_r = 64'hAAAA_BBBB_CCCC_DDDD; b_ack = 1;
    step();
    b_ack = 0;
    check("bf_rsp", {b_irv, b_ire, b_drr}, 3'b100);
    check("bf_inst", b_inst, 32'hAAAA_BBBB);
    // ack and err together: error wins
    b_iv = 1; b_pc = 32'h300;
    step();
    b_iv = 0;
    b_ack = 1; b_err = 1;
    step();
    b_ack = 0; b_err = 0;
    check("bae_rsp", {b_irv, b_ire}, 2'b11);
    step();

`ifdef FWVEXRISC_WB_BRIDGE_TIMEOUT_EN
    // A: no ack, watchdog ends the cycle after 8 cycles
    a_dv = 1; a_dwr = 0; a_dadr = 32'h400; a_dsz = 2'd2; a_dat_r = 32'hFFFF_FFFF;
    step();
    a_dv = 0;
    for (int k = 2; k <= 8; k++) begin
      step();
      check("to_wait", {a_cyc, a_drr}, 2'b10);
    end
    step();
    check("to_rsp", {a_drr, a_dre}, 2'b11);
    check("to_data", a_drd, 32'h0);
    check("to_cyc", a_cyc, 1'b0);
    step(); step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
